digit_serial_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes `DIGIT` bits per clock, LSB first, over a `WIDTH`-bit operand pair. It generalises the 8-bit ripple-carry adder by adding:
- configurable width and digit size,
- a subtract mode with borrow semantics,
- registered status flags,
- a start/busy/done handshake.

It sits in the datapath wherever a narrow, area-cheap adder is traded for latency.

---
 rtl/digit_serial_addsub.sv | 102 ++++++++++
 tb/tb_digit_serial_addsub.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract, DIGIT bits per cycle LSB first; result and oDone appear N=WIDTH/DIGIT cycles after accept.
// No backpressure: iStart is sampled only while idle and is ignored (never queued) while busy.
module digit_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOverflow,
  output logic             oZero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

  stateT            state;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] sumSr;
  logic             carry;
  logic             subMode;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   digitSum;
  logic [WIDTH-1:0] digitExt;
  logic [WIDTH-1:0] sumNext;
  logic             msbCarryIn;
  logic             lastDigit;

  always_comb begin
    digitSum = {1'b0, regA[DIGIT-1:0]} + {1'b0, regB[DIGIT-1:0]} + (DIGIT+1)'(carry);
    digitExt = '0;
    digitExt[DIGIT-1:0] = digitSum[DIGIT-1:0];
    sumNext = (sumSr >> DIGIT) | (digitExt << (WIDTH - DIGIT));
    // Sum bit = a ^ b ^ cin, so the carry into the digit's top bit is recoverable from it.
    msbCarryIn = regA[DIGIT-1] ^ regB[DIGIT-1] ^ digitSum[DIGIT-1];
    lastDigit = (cnt == CW'(N - 1));
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= IDLE;
      regA      <= '0;
      regB      <= '0;
      sumSr     <= '0;
      carry     <= 1'b0;
      subMode   <= 1'b0;
      cnt       <= '0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oData     <= '0;
      oData_C   <= 1'b0;
      oOverflow <= 1'b0;
      oZero     <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            regA    <= iData_a;
            regB    <= iSub ? ~iData_b : iData_b;
            carry   <= iSub ^ iC;
            subMode <= iSub;
            sumSr   <= '0;
            cnt     <= '0;
            oBusy   <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          regA  <= regA >> DIGIT;
          regB  <= regB >> DIGIT;
          carry <= digitSum[DIGIT];
          sumSr <= sumNext;
          cnt   <= cnt + CW'(1);
          if (lastDigit) begin
            oData     <= sumNext;
            oData_C   <= subMode ^ digitSum[DIGIT];
            oOverflow <= msbCarryIn ^ digitSum[DIGIT];
            oZero     <= (sumNext == '0);
            oDone     <= 1'b1;
            oBusy     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: directed cases on an 8/2 instance plus a shared random sweep
// over five width/digit configurations, all driven from the same stimulus.
module tb_digit_serial_addsub;

  localparam int NI = 5;

  function automatic int wOf(int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 8;
      3: return 16;
      default: return 12;
    endcase
  endfunction

  function automatic int dOf(int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 8;
      3: return 4;
      default: return 3;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rstN;
  logic          startIn;
  logic          subIn;
  logic          cIn;
  logic [15:0]   aIn;
  logic [15:0]   bIn;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [NI-1:0] cOut;
  logic [NI-1:0] ovf;
  logic [NI-1:0] zero;
  logic [15:0]   dOut [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gDut
    localparam int W = wOf(g);
    localparam int D = dOf(g);
    logic [W-1:0] d;
    digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
      .iClk      (clk),
      .iRst_n    (rstN),
      .iStart    (startIn),
      .iSub      (subIn),
      .iData_a   (aIn[W-1:0]),
      .iData_b   (bIn[W-1:0]),
      .iC        (cIn),
      .oBusy     (busy[g]),
      .oDone     (done[g]),
      .oData     (d),
      .oData_C   (cOut[g]),
      .oOverflow (ovf[g]),
      .oZero     (zero[g])
    );
    assign dOut[g] = 16'(d);
  end

  task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic over w bits, signed overflow from exact signed range.
  function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                input logic s, input logic c, output logic [15:0] res,
                                output logic co, output logic ov, output logic z);
    longint m, ua, ub, half, sa, sb, full, sr, cc;
    m    = (longint'(1) << w) - 1;
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    cc   = c ? 1 : 0;
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb   = (ub >= half) ? ub - (longint'(1) << w) : ub;
    if (!s) begin
      full = ua + ub + cc;
      co   = (full >> w) != 0;
      sr   = sa + sb + cc;
    end else begin
      full = ua - ub - cc;
      co   = ua < ub + cc;
      sr   = sa - sb - cc;
    end
    res = 16'(full & m);
    ov  = (sr >= half) || (sr < -half);
    z   = (full & m) == 0;
  endfunction

  task automatic waitDone0(output int n);
    n = 0;
    while (!done[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Launch one operation, then scramble all operand inputs right after the accept edge.
  task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c,
                     output int lat);
    @(negedge clk);
    aIn = a; bIn = b; subIn = s; cIn = c; startIn = 1'b1;
    @(posedge clk); #1;
    startIn = 1'b0;
    aIn = 16'($urandom); bIn = 16'($urandom); subIn = ~s; cIn = ~c;
    waitDone0(lat);
  endtask

  task automatic expect0(input string tag, input int lat, input int expLat, input logic [7:0] d,
                         input logic c, input logic o, input logic z);
    chkVal({tag, ".lat"}, lat, expLat);
    chkVal({tag, ".data"}, dOut[0], {8'h0, d});
    chkVal({tag, ".carry"}, cOut[0], c);
    chkVal({tag, ".ovf"}, ovf[0], o);
    chkVal({tag, ".zero"}, zero[0], z);
    chkVal({tag, ".busy"}, busy[0], 1'b0);
    @(posedge clk); #1;
    chkVal({tag, ".pulse"}, done[0], 1'b0);
  endtask

  task automatic runSweep(input int ops);
    logic [15:0] ra, rb, eD, capD [NI];
    logic        rs, rc, eC, eO, eZ;
    logic        capC [NI], capO [NI], capZ [NI];
    int          lat [NI], dc [NI];
    for (int k = 0; k < ops; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      if (k < 8) begin
        ra = (k[0]) ? 16'hFFFF : 16'h0000;
        rb = (k[1]) ? 16'hFFFF : 16'h0000;
        rs = k[2];
      end
      @(negedge clk);
      aIn = ra; bIn = rb; subIn = rs; cIn = rc; startIn = 1'b1;
      @(posedge clk); #1;
      startIn = 1'b0;
      aIn = 16'($urandom); bIn = 16'($urandom); subIn = ~rs; cIn = ~rc;
      for (int g = 0; g < NI; g++) begin
        chkVal($sformatf("sweep.busy[%0d]", g), busy[g], 1'b1);
        lat[g] = 0; dc[g] = 0;
        capD[g] = '0; capC[g] = 1'b0; capO[g] = 1'b0; capZ[g] = 1'b0;
      end
      for (int cyc = 1; cyc <= 10; cyc++) begin
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
          if (done[g]) begin
            dc[g]++;
            if (lat[g] == 0) begin
              lat[g] = cyc;
              capD[g] = dOut[g]; capC[g] = cOut[g]; capO[g] = ovf[g]; capZ[g] = zero[g];
            end
          end
        end
      end
      for (int g = 0; g < NI; g++) begin
        model(wOf(g), ra, rb, rs, rc, eD, eC, eO, eZ);
        chkVal($sformatf("sweep.lat[%0d]", g), lat[g], wOf(g) / dOf(g));
        chkVal($sformatf("sweep.doneCnt[%0d]", g), dc[g], 1);
        chkVal($sformatf("sweep.data[%0d] a=%0h b=%0h s=%0b c=%0b", g, ra, rb, rs, rc), capD[g], eD);
        chkVal($sformatf("sweep.carry[%0d]", g), capC[g], eC);
        chkVal($sformatf("sweep.ovf[%0d]", g), capO[g], eO);
        chkVal($sformatf("sweep.zero[%0d]", g), capZ[g], eZ);
        chkVal($sformatf("sweep.hold[%0d]", g), dOut[g], eD);
      end
    end
  endtask

  initial begin
    int lat, n;
    int dq[$];
    rstN = 1'b0; startIn = 1'b0; subIn = 1'b0; cIn = 1'b0; aIn = '0; bIn = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chkVal($sformatf("reset.data[%0d]", g), dOut[g], 0);
      chkVal($sformatf("reset.busy[%0d]", g), busy[g], 1'b0);
      chkVal($sformatf("reset.done[%0d]", g), done[g], 1'b0);
      chkVal($sformatf("reset.flags[%0d]", g), {cOut[g], ovf[g], zero[g]}, 3'b000);
    end
    @(negedge clk);
    rstN = 1'b1;

    op0(16'h3C, 16'h45, 1'b0, 1'b1, lat);
    expect0("add", lat, 4, 8'h82, 1'b0, 1'b1, 1'b0);
    op0(16'hFF, 16'h01, 1'b0, 1'b0, lat);
    expect0("addWrap", lat, 4, 8'h00, 1'b1, 1'b0, 1'b1);
    op0(16'h10, 16'h20, 1'b1, 1'b0, lat);
    expect0("subBorrow", lat, 4, 8'hF0, 1'b1, 1'b0, 1'b0);
    op0(16'h80, 16'h01, 1'b1, 1'b0, lat);
    expect0("subOvf", lat, 4, 8'h7F, 1'b0, 1'b1, 1'b0);

    // A second request arriving mid-run must be dropped, not queued.
    @(negedge clk);
    aIn = 16'h12; bIn = 16'h34; subIn = 1'b0; cIn = 1'b0; startIn = 1'b1;
    @(posedge clk); #1;
    startIn = 1'b0;
    @(posedge clk); #1;
    aIn = 16'hAA; bIn = 16'h55; subIn = 1'b1; startIn = 1'b1;
    @(posedge clk); #1;
    startIn = 1'b0;
    waitDone0(lat);
    expect0("midStart", lat, 2, 8'h46, 1'b0, 1'b0, 1'b0);
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      n += int'(done[0]);
    end
    chkVal("midStart.noSecond", n, 0);

    // Start held high: completions every N+1 edges.
    @(negedge clk);
    aIn = 16'h01; bIn = 16'h02; subIn = 1'b0; cIn = 1'b0; startIn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done[0]) begin
        dq.push_back(i);
        chkVal("b2b.data", dOut[0], 16'h03);
      end
    end
    startIn = 1'b0;
    chkVal("b2b.count", dq.size(), 5);
    foreach (dq[j]) chkVal($sformatf("b2b.edge%0d", j), dq[j], 4 + 5 * j);

    // Reset two cycles into a run.
    @(negedge clk);
    aIn = 16'h10; bIn = 16'h22; subIn = 1'b0; cIn = 1'b0; startIn = 1'b1;
    @(posedge clk); #1;
    startIn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN = 1'b0;
    #1;
    chkVal("abort.data", dOut[0], 0);
    chkVal("abort.busy", busy[0], 1'b0);
    chkVal("abort.done", done[0], 1'b0);
    chkVal("abort.flags", {cOut[0], ovf[0], zero[0]}, 3'b000);
    @(negedge clk);
    rstN = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      n += int'(done[0]);
    end
    chkVal("abort.noDone", n, 0);
    op0(16'h7F, 16'h01, 1'b0, 1'b0, lat);
    expect0("afterAbort", lat, 4, 8'h80, 1'b0, 1'b1, 1'b0);

    repeat (12) @(posedge clk);
    runSweep(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
